// File: rtl/corebootstrap_spi_loader.sv
// Boot image fetch: READ 0x03 from SPI flash, streams NUM_WORDS words to the writer, then checks a trailing sum word.
// Latency: first SCK rise SCLK_DIV cycles after SS falls; each word is strobed one HCLK after its 32nd sampled bit.
// Backpressure: none; rd_data holds from one strobe to the next, which gives the writer 64*SCLK_DIV HCLK cycles per word.
module corebootstrap_spi_loader #(
  parameter logic [23:0] SPI_SRC_ADDR = 24'h000000,
  parameter int          NUM_WORDS    = 1024,
  parameter int          SCLK_DIV     = 2
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  output logic        SPI_SCK,
  output logic        SPI_SS,
  output logic        SPI_SDO,
  input  logic        SPI_SDI,
  output logic [31:0] rd_data,
  output logic        rd_data_avail,
  output logic        rd_all_done,
  output logic        cksum_done,
  output logic        CKSUM_ERR,
  output logic        busy
);

  localparam int WCW = $clog2(NUM_WORDS + 1);
  localparam int DCW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [7:0]     READ_CMD  = 8'h03;
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(SCLK_DIV - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_CKSUM,
    S_DONE
  } state_t;

  state_t state, next_state;

  // SCK divider and bit/word bookkeeping
  logic [DCW-1:0] div_cnt;
  logic [4:0]     bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic [31:0]    tx_sr;
  logic [31:0]    rx_sr;
  logic [31:0]    acc;
  // Set on the 32nd sample of a word; consumed on the following HCLK.
  logic           word_rdy;

  // Decoded controls from the next-state logic
  logic        active;
  logic        tick;
  logic        sck_rise;
  logic        sck_fall;
  logic        start;
  logic        cmd_done;
  logic        sample;
  logic        present;
  logic        last_word;
  logic        finish;
  logic [31:0] rx_word;

  // State register
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    next_state = state;
    start      = 1'b0;
    cmd_done   = 1'b0;
    sample     = 1'b0;
    present    = 1'b0;
    last_word  = 1'b0;
    finish     = 1'b0;
    active     = (state == S_CMD) || (state == S_DATA) || (state == S_CKSUM);
    tick       = active && (div_cnt == DIV_LAST);
    sck_rise   = tick && !SPI_SCK;
    sck_fall   = tick && SPI_SCK;
    // Bytes arrive MSB first; the first byte on the wire is the least significant.
    rx_word    = {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
    case (state)
      S_IDLE: begin
        start      = 1'b1;
        next_state = S_CMD;
      end
      S_CMD: begin
        if (sck_fall && (bit_cnt == 5'd31)) begin
          cmd_done   = 1'b1;
          next_state = S_DATA;
        end
      end
      S_DATA: begin
        sample  = sck_rise;
        present = word_rdy;
        if (word_rdy && (word_cnt == LAST_WORD)) begin
          last_word  = 1'b1;
          next_state = S_CKSUM;
        end
      end
      S_CKSUM: begin
        sample = sck_rise;
        if (word_rdy) begin
          finish     = 1'b1;
          next_state = S_DONE;
        end
      end
      default: begin
        next_state = state;
      end
    endcase
  end

  // SPI pins, shift registers, word presentation and checksum datapath
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      SPI_SS        <= 1'b1;
      SPI_SCK       <= 1'b0;
      SPI_SDO       <= 1'b0;
      rd_data       <= '0;
      rd_data_avail <= 1'b0;
      rd_all_done   <= 1'b0;
      cksum_done    <= 1'b0;
      CKSUM_ERR     <= 1'b0;
      busy          <= 1'b0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      acc           <= '0;
      word_rdy      <= 1'b0;
    end else begin
      rd_data_avail <= 1'b0;
      if (start) begin
        // First command bit goes out together with SS falling.
        SPI_SS   <= 1'b0;
        busy     <= 1'b1;
        SPI_SCK  <= 1'b0;
        SPI_SDO  <= READ_CMD[7];
        tx_sr    <= {READ_CMD, SPI_SRC_ADDR};
        div_cnt  <= '0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        acc      <= '0;
        word_rdy <= 1'b0;
      end else if (active) begin
        if (tick) begin
          div_cnt <= '0;
          SPI_SCK <= ~SPI_SCK;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end

        // Command bits advance on SCK falling; counter wraps to 0 for the data phase.
        if ((state == S_CMD) && sck_fall) begin
          bit_cnt <= bit_cnt + 5'd1;
          tx_sr   <= tx_sr << 1;
          SPI_SDO <= cmd_done ? 1'b0 : tx_sr[30];
        end

        if (sample) begin
          rx_sr   <= {rx_sr[30:0], SPI_SDI};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            word_rdy <= 1'b1;
          end
        end

        if (present) begin
          rd_data       <= rx_word;
          rd_data_avail <= 1'b1;
          acc           <= acc + rx_word;
          word_cnt      <= word_cnt + 1'b1;
          word_rdy      <= 1'b0;
          if (last_word) begin
            rd_all_done <= 1'b1;
          end
        end

        // Checksum word never reaches rd_data: the writer may still be using the last data word.
        if (finish) begin
          CKSUM_ERR  <= (acc != rx_word);
          cksum_done <= 1'b1;
          SPI_SS     <= 1'b1;
          SPI_SCK    <= 1'b0;
          busy       <= 1'b0;
          word_rdy   <= 1'b0;
          div_cnt    <= '0;
        end
      end
    end
  end

endmodule
